// File: rtl/dmem_responder_if.sv
// Load/store request and response bus between the memory stage and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency, byte/half/word lanes,
// sign/zero extension on loads, and error reporting for misaligned/out-of-range/illegal accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ready_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic             cap_we;
    logic [2:0]       cap_func3;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;

    logic             accept_c;
    logic             access_c;
    logic             err_c;
    logic             f3_legal_c;
    logic             misaligned_c;
    logic             out_of_range_c;
    logic [AW-1:0]    word_idx_c;
    logic [1:0]       lane_c;
    logic [31:0]      rd_word_c;
    logic [15:0]      lane_data_c;
    logic [31:0]      load_data_c;
    logic [3:0]       wr_be_c;
    logic [31:0]      wr_data_c;

    logic [31:0]      mem [0:DEPTH_WORDS-1];

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Next-state logic: accept in IDLE, count down the latency in WAIT, one-cycle RESP.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        access_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    accept_c   = 1'b1;
                    next_state = S_WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    access_c   = 1'b1;
                    next_state = S_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State, counter and handshake flags; ready/valid are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= cnt_next;
            ready_q      <= (next_state == S_IDLE);
            resp_valid_q <= (next_state == S_RESP);
        end
    end

    // Request capture at accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_we    <= 1'b0;
            cap_func3 <= 3'b000;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept_c) begin
            cap_we    <= bus.req_we;
            cap_func3 <= bus.req_func3;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
        end
    end

    // Access legality on the captured request.
    always_comb begin
        if (cap_we) begin
            f3_legal_c = (cap_func3 == 3'b000) || (cap_func3 == 3'b001) || (cap_func3 == 3'b010);
        end else begin
            f3_legal_c = (cap_func3 != 3'b011) && (cap_func3 != 3'b110) && (cap_func3 != 3'b111);
        end
        misaligned_c   = ((cap_func3[1:0] == 2'b01) && cap_addr[0]) ||
                         ((cap_func3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
        out_of_range_c = |cap_addr[31:AW+2];
        err_c          = !f3_legal_c || misaligned_c || out_of_range_c;
    end

    // Lane selection and extension for loads; byte enables and replicated data for stores.
    always_comb begin
        word_idx_c  = cap_addr[AW+1:2];
        lane_c      = cap_addr[1:0];
        rd_word_c   = mem[word_idx_c];
        lane_data_c = 16'(rd_word_c >> {lane_c, 3'b000});
        case (cap_func3)
            3'b000:  load_data_c = {{24{lane_data_c[7]}}, lane_data_c[7:0]};
            3'b100:  load_data_c = {24'h0, lane_data_c[7:0]};
            3'b001:  load_data_c = {{16{lane_data_c[15]}}, lane_data_c};
            3'b101:  load_data_c = {16'h0, lane_data_c};
            default: load_data_c = rd_word_c;
        endcase
        case (cap_func3[1:0])
            2'b00: begin
                wr_be_c   = 4'b0001 << lane_c;
                wr_data_c = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                wr_be_c   = 4'b0011 << lane_c;
                wr_data_c = {2{cap_wdata[15:0]}};
            end
            default: begin
                wr_be_c   = 4'b1111;
                wr_data_c = cap_wdata;
            end
        endcase
    end

    // Data array write on the access edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (access_c && cap_we && !err_c) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_c[i]) begin
                    mem[word_idx_c][i*8 +: 8] <= wr_data_c[i*8 +: 8];
                end
            end
        end
    end

    // Response data/error, held until the next access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (access_c) begin
            resp_rdata_q <= (err_c || cap_we) ? 32'h0 : load_data_c;
            resp_err_q   <= err_c;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed spec scenarios plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] ref_mem [0:DEPTH*4-1];

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: byte-addressed memory; size/alignment/range rules applied arithmetically.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] exp_rd,
                                output logic exp_err);
        int     size;
        bit     legal;
        longint val;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal   = we ? (f3 <= 3'd2) : (size != 0);
        exp_err = !legal || (addr >= 32'(DEPTH * 4)) || (size > 0 && (addr % 32'(size)) != 0);
        exp_rd  = 32'h0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < size; b++) ref_mem[addr + 32'(b)] = 8'(wdata >> (8 * b));
            end else begin
                val = 0;
                for (int b = 0; b < size; b++) val += longint'(ref_mem[addr + 32'(b)]) << (8 * b);
                if (f3[2] == 1'b0 && size < 4 && val >= (64'sd1 << (8 * size - 1)))
                    val -= (64'sd1 << (8 * size));
                exp_rd = 32'(val);
            end
        end
    endtask

    // Drive one request; report response, edges from accept to strobe, and strobe width.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                       output int lat, output bit single);
        int  n;
        bit  seen;
        lat    = 99;
        single = 1'b0;
        seen   = 1'b0;
        rd     = 32'hx;
        er     = 1'bx;
        n      = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_func3 = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (bus.resp_valid) begin
                    seen = 1'b1;
                    lat  = i;
                    rd   = bus.resp_rdata;
                    er   = bus.resp_err;
                end
            end
        end
        if (seen) begin
            @(posedge clk);
            #1;
            single = !bus.resp_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_values: ready %b valid %b err %b rdata %h, want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready %b valid %b, want ready 1 valid 0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    // Directed vectors with spec constants (basic, extension, partial stores, errors).
    task automatic run_directed(input string tag, input vec_t v[$]);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          single;
        foreach (v[i]) begin
            txn(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat, single);
            n_cmp++;
            if (lat !== int'(LAT) || !single) begin
                n_fail++;
                $display("FAIL %s[%0d] timing: lat %0d single %0d, want lat %0d single 1",
                         tag, i, lat, single, LAT);
            end
            n_cmp++;
            if (er !== v[i].err || rd !== v[i].rd) begin
                n_fail++;
                $display("FAIL %s[%0d] resp: err %b rdata %h, want err %b rdata %h",
                         tag, i, er, rd, v[i].err, v[i].rd);
            end
        end
    endtask

    task automatic test_basic();
        vec_t v[$];
        v.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
        v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 3'd2, 32'h14, 32'h0BADF00D, 32'h0, 1'b0});
        v.push_back('{1'b0, 3'd2, 32'h14, 32'h0, 32'h0BADF00D, 1'b0});
        run_directed("basic", v);
    endtask

    task automatic test_extension();
        vec_t v[$];
        v.push_back('{1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0});
        v.push_back('{1'b0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 1'b0});
        v.push_back('{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0});
        v.push_back('{1'b0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 1'b0});
        v.push_back('{1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0});
        run_directed("ext", v);
    endtask

    task automatic test_partial_store();
        vec_t v[$];
        v.push_back('{1'b1, 3'd0, 32'h11, 32'h000000AA, 32'h0, 1'b0});
        v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0});
        v.push_back('{1'b1, 3'd1, 32'h12, 32'h00001234, 32'h0, 1'b0});
        v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'h1234AAEF, 1'b0});
        run_directed("partial", v);
    endtask

    task automatic test_errors();
        vec_t v[$];
        v.push_back('{1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1});
        v.push_back('{1'b1, 3'd1, 32'h11, 32'h0000FFFF, 32'h0, 1'b1});
        v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'h1234AAEF, 1'b0});
        v.push_back('{1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1});
        v.push_back('{1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1});
        v.push_back('{1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1});
        v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'h1234AAEF, 1'b0});
        run_directed("err", v);
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          single;
        bit          bad_valid;
        bit          bad_ready;
        vec_t        v[$];
        txn(1'b1, 3'd2, 32'h20, 32'h0, rd, er, lat, single);
        n_cmp++;
        if (er !== 1'b0 || lat !== int'(LAT)) begin
            n_fail++;
            $display("FAIL midop_first_store: err %b lat %0d, want err 0 lat %0d", er, lat, LAT);
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_func3 = 3'd2;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h55;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad_valid = 1'b0;
        bad_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) bad_valid = 1'b1;
            if (bus.req_ready !== 1'b0) bad_ready = 1'b1;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) bad_valid = 1'b1;
        end
        n_cmp++;
        if (bad_valid) begin
            n_fail++;
            $display("FAIL midop_no_resp: resp_valid seen 1, want 0 for dropped request");
        end
        n_cmp++;
        if (bad_ready) begin
            n_fail++;
            $display("FAIL midop_ready_in_reset: req_ready seen 1, want 0 while reset low");
        end
        v.push_back('{1'b0, 3'd2, 32'h20, 32'h0, 32'h00000000, 1'b0});
        run_directed("midop_load", v);
    endtask

    task automatic test_back_to_back();
        int          acc[$];
        logic [31:0] prd[$];
        bit          rdy_tr[40];
        bit          ok;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_func3 = 3'd2;
        bus.req_addr  = 32'h10;
        for (int c = 0; c < 30; c++) begin
            rdy_tr[c] = bus.req_ready;
            if (bus.resp_valid) prd.push_back(bus.resp_rdata);
            if (bus.req_ready && bus.req_valid) acc.push_back(c);
            @(posedge clk);
            #1;
            if (acc.size() == 1) bus.req_addr = 32'h14;
            if (acc.size() == 2) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (acc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d accepts, want 2", acc.size());
        end else begin
            n_cmp++;
            if (acc[1] - acc[0] != int'(LAT) + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d edges, want %0d", acc[1] - acc[0], LAT + 2);
            end
            foreach (acc[a]) begin
                ok = 1'b1;
                for (int k = 1; k <= int'(LAT) + 1; k++) if (rdy_tr[acc[a] + k]) ok = 1'b0;
                n_cmp++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL b2b_ready_low[%0d]: req_ready high within %0d cycles of accept, want 0",
                             a, LAT + 1);
                end
            end
        end
        n_cmp++;
        if (prd.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d resp_valid pulses, want 2", prd.size());
        end else begin
            n_cmp++;
            if (prd[0] !== 32'h1234AAEF || prd[1] !== 32'h0BADF00D) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h, want 1234aaef 0badf00d", prd[0], prd[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, wdata;
        logic        er, exp_err, we;
        logic [2:0]  f3;
        int          lat;
        bit          single;
        for (int i = 0; i < 76; i++) begin
            if (i < 16) begin
                we    = 1'b1;
                f3    = 3'd2;
                addr  = 32'(i * 4);
            end else begin
                we    = 1'($urandom);
                f3    = 3'($urandom);
                addr  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
            end
            wdata = $urandom;
            model_access(we, f3, addr, wdata, exp_rd, exp_err);
            txn(we, f3, addr, wdata, rd, er, lat, single);
            n_cmp++;
            if (lat !== int'(LAT) || !single) begin
                n_fail++;
                $display("FAIL rand[%0d] timing: lat %0d single %0d, want lat %0d single 1",
                         i, lat, single, LAT);
            end
            n_cmp++;
            if (er !== exp_err || rd !== exp_rd) begin
                n_fail++;
                $display("FAIL rand[%0d] we=%b f3=%0d addr=%h: err %b rdata %h, want err %b rdata %h",
                         i, we, f3, addr, er, rd, exp_err, exp_rd);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_func3 = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        test_reset();
        test_basic();
        test_extension();
        test_partial_store();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
